// File: rtl/board_pkg.sv
// board_pkg: shared board constants and debounce state encoding.
package board_pkg;
    localparam int CLK_HZ = 100_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int SW_WIDTH = 8;
    localparam logic [SW_WIDTH-1:0] SW_RST_VAL = 8'h80;
    localparam logic DB_STABLE = 1'b0;
    localparam logic DB_PEND = 1'b1;
    typedef enum logic {ST_STABLE = DB_STABLE, ST_PEND = DB_PEND} db_state_t;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one switch channel; 2-flop synchroniser, stability counter and update flag.
module debounce_cell
    import board_pkg::*;
#(
    parameter int   STABLE_CYCLES = DB_CYCLES,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_out,
    output logic upd
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    db_state_t state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= {2{RST_BIT}};
            state  <= ST_STABLE;
            cnt    <= '0;
            sw_out <= RST_BIT;
            upd    <= 1'b0;
        end else begin
            sync <= {sync[0], sw_in};
            upd  <= 1'b0;
            if (state == ST_STABLE) begin
                if (sync[1] != sw_out) begin
                    state <= ST_PEND;
                    cnt   <= CNT_W'(1);
                end
            end else if (sync[1] == sw_out) begin
                state <= ST_STABLE;
                cnt   <= '0;
            end else if (cnt == LAST) begin
                sw_out <= sync[1];
                upd    <= 1'b1;
                state  <= ST_STABLE;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: per-bit debounced switch bus with a change strobe.
// DEBOUNCE_EDGE_EN adds per-bit sw_rise/sw_fall pulses.
module switch_debounce
    import board_pkg::*;
#(
    parameter int               WIDTH = SW_WIDTH,
    parameter int               STABLE_CYCLES = DB_CYCLES,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(SW_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_change
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`endif
);
    logic [WIDTH-1:0] upd;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(.STABLE_CYCLES(STABLE_CYCLES), .RST_BIT(RST_VAL[i])) u_cell (
            .clk(clk),
            .rst_n(rst_n),
            .sw_in(sw_in[i]),
            .sw_out(sw_out[i]),
            .upd(upd[i])
        );
    end
    assign sw_change = |upd;
`ifdef DEBOUNCE_EDGE_EN
    // update flags are registered alongside sw_out, so these line up with the new level
    assign sw_rise = upd & sw_out;
    assign sw_fall = upd & ~sw_out;
`endif
endmodule
